// File: rtl/name_scroller.sv
// rtl/name_scroller.sv - scrolling message source for the 8-digit seven-segment path
//
// Purpose:
//   Holds a writable MSG_LEN-entry buffer of 5-bit character codes. It advances a
//   scroll window by one character every STEP_DIV clocks while enabled. It also
//   returns the registered code for the digit picked by the anode counter.
//
// Build option:
//   SCROLL_PAUSE_EN - when defined, adds a PAUSE state that dwells PAUSE_STEPS
//                     steps at offset 0 after each wrap. When undefined, the
//                     scroll wraps straight to 0 and keeps going.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   enable     in   scroll enable, level-sensitive
//   wr_en      in   message write strobe, one word per cycle
//   wr_addr    in   [4:0] message write index (>= MSG_LEN ignored)
//   wr_data    in   [4:0] character code to write
//   digit_sel  in   [2:0] digit index from the anode counter, 0 = rightmost
//   char_code  out  [4:0] registered code for the selected digit, 5'h1F = blank
//   offset     out  [4:0] current scroll offset, 0..MSG_LEN-1
//   wrap       out  one-cycle pulse when offset wraps to 0
module name_scroller #(
  parameter int MSG_LEN     = 16,
  parameter int STEP_DIV    = 25_000_000,
  parameter int PAUSE_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [2:0] digit_sel,
  output logic [4:0] char_code,
  output logic [4:0] offset,
  output logic       wrap
);

  localparam int            CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);
  localparam logic [4:0]    OFF_LAST  = 5'(MSG_LEN - 1);
  localparam logic [5:0]    LEN6      = 6'(MSG_LEN);
  localparam logic [4:0]    BLANK     = 5'h1F;

`ifdef SCROLL_PAUSE_EN
  localparam int            PW         = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_STEPS - 1);
  typedef enum logic [1:0] {IDLE, SCROLL, PAUSE} state_t;
  logic [PW-1:0] pause_cnt;
`else
  typedef enum logic {IDLE, SCROLL} state_t;
`endif

  state_t        state;
  logic [CW-1:0] step_cnt;
  logic          step;
  logic [4:0]    mem [MSG_LEN];
  logic [5:0]    sum;
  logic [5:0]    rd_idx;
  logic [4:0]    rd_data;

  // The counter is held at 0 in IDLE, and STEP_DIV >= 2, so the state gate
  // only guards against a counter that has not yet been cleared.
  assign step = (state != IDLE) && (step_cnt == STEP_LAST);

  // The offset is always below MSG_LEN and digit_sel is at most 7, so a single
  // conditional subtract is enough to fold the sum back into range.
  always_comb begin
    sum     = {1'b0, offset} + {3'b000, digit_sel};
    rd_idx  = (sum >= LEN6) ? (sum - LEN6) : sum;
    rd_data = BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (rd_idx == 6'(i)) rd_data = mem[i];
    end
  end

  // Buffer and read register. A same-index write and read on one edge return
  // the old code, because both sides sample the pre-edge contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= BLANK;
      char_code <= BLANK;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_en && (wr_addr == 5'(i))) mem[i] <= wr_data;
      end
      char_code <= rd_data;
    end
  end

  // Scroll FSM. A low enable wins over a coincident step, and the offset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      offset   <= 5'd0;
      wrap     <= 1'b0;
      step_cnt <= '0;
`ifdef SCROLL_PAUSE_EN
      pause_cnt <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          step_cnt <= '0;
          if (enable) state <= SCROLL;
        end

        SCROLL: begin
          if (!enable) begin
            state    <= IDLE;
            step_cnt <= '0;
`ifdef SCROLL_PAUSE_EN
            pause_cnt <= '0;
`endif
          end else begin
            step_cnt <= step ? '0 : step_cnt + CW'(1);
            if (step) begin
              if (offset == OFF_LAST) begin
                offset <= 5'd0;
                wrap   <= 1'b1;
`ifdef SCROLL_PAUSE_EN
                state  <= PAUSE;
`endif
              end else begin
                offset <= offset + 5'd1;
              end
            end
          end
        end

`ifdef SCROLL_PAUSE_EN
        PAUSE: begin
          if (!enable) begin
            state     <= IDLE;
            step_cnt  <= '0;
            pause_cnt <= '0;
          end else begin
            step_cnt <= step ? '0 : step_cnt + CW'(1);
            if (step) begin
              if (pause_cnt == PAUSE_LAST) begin
                pause_cnt <= '0;
                state     <= SCROLL;
              end else begin
                pause_cnt <= pause_cnt + PW'(1);
              end
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          step_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_name_scroller.sv
// tb/tb_name_scroller.sv - self-checking bench for name_scroller
module tb_name_scroller;

  localparam int MSG_LEN     = 10;
  localparam int STEP_DIV    = 4;
  localparam int PAUSE_STEPS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [4:0] wr_data = 5'd0;
  logic [2:0] digit_sel = 3'd0;
  logic [4:0] char_code;
  logic [4:0] offset;
  logic       wrap;

  name_scroller #(
    .MSG_LEN    (MSG_LEN),
    .STEP_DIV   (STEP_DIV),
    .PAUSE_STEPS(PAUSE_STEPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .digit_sel(digit_sel),
    .char_code(char_code),
    .offset   (offset),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] code;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic [4:0] sb [$];
  logic [4:0] exp_mem [MSG_LEN];
  vec_t       vecs [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [4:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no expected entry expected one queued", name);
    end else begin
      e = sb.pop_front();
      check(name, char_code, e);
    end
  endtask

  task automatic write_word(input int a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    if (a < MSG_LEN) exp_mem[a] = d;
    tick;
    wr_en = 1'b0;
  endtask

  // Expected offset c cycles after the edge that first samples enable=1.
  function automatic int exp_off(input int c);
`ifdef SCROLL_PAUSE_EN
    int d;
    if (c < MSG_LEN * STEP_DIV) return c / STEP_DIV;
    d = (c - MSG_LEN * STEP_DIV) % ((MSG_LEN + PAUSE_STEPS) * STEP_DIV);
    if (d < (PAUSE_STEPS + 1) * STEP_DIV) return 0;
    return (d - (PAUSE_STEPS + 1) * STEP_DIV) / STEP_DIV + 1;
`else
    return (c / STEP_DIV) % MSG_LEN;
`endif
  endfunction

  function automatic int exp_wrap(input int c);
`ifdef SCROLL_PAUSE_EN
    return (c >= MSG_LEN * STEP_DIV &&
            ((c - MSG_LEN * STEP_DIV) % ((MSG_LEN + PAUSE_STEPS) * STEP_DIV)) == 0) ? 1 : 0;
`else
    return (c > 0 && (c % (MSG_LEN * STEP_DIV)) == 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    int prev;

    for (int i = 0; i < MSG_LEN; i++) exp_mem[i] = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      vecs[i].sel  = 3'(i);
      vecs[i].code = 5'(i);
    end

    // Reset state
    repeat (2) tick;
    reset = 1'b1;
    tick;
    check("rst_offset", offset, 0);
    check("rst_wrap", wrap, 0);
    check("rst_code", char_code, 5'h1F);

    // Load, scroll a little, then reset asynchronously mid-scroll
    for (int i = 0; i < MSG_LEN; i++) write_word(i, 5'(i + 3));
    enable = 1'b1;
    repeat (10) tick;
    check("pre_rst_offset", offset, 2);
    #3 reset = 1'b0;
    #1;
    check("async_rst_offset", offset, 0);
    check("async_rst_code", char_code, 5'h1F);
    check("async_rst_wrap", wrap, 0);
    for (int i = 0; i < MSG_LEN; i++) exp_mem[i] = 5'h1F;
    enable = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    check("post_rst_offset", offset, 0);

    // Every entry reads back blank after reset
    for (int s = 0; s < 8; s++) begin
      digit_sel = 3'(s);
      sb.push_back(exp_mem[s % MSG_LEN]);
      tick;
      sb_check("rst_sweep");
    end

    // Load 0..9, then an out-of-range write that must be dropped
    for (int i = 0; i < MSG_LEN; i++) write_word(i, 5'(i));
    write_word(12, 5'h07);
    for (int v = 0; v < 8; v++) begin
      digit_sel = vecs[v].sel;
      sb.push_back(vecs[v].code);
      tick;
      sb_check("load_read");
    end

    // Write and read of index 5 on the same edge
    digit_sel = 3'd5;
    sb.push_back(exp_mem[5]);
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 5'h0A;
    tick;
    wr_en = 1'b0;
    exp_mem[5] = 5'h0A;
    sb_check("coll_old");
    sb.push_back(exp_mem[5]);
    tick;
    sb_check("coll_new");

    // Scroll with digit_sel=5 across two wraps
    enable = 1'b1;
    prev = 0;
    for (int c = 0; c <= 100; c++) begin
      sb.push_back(exp_mem[(prev + 5) % MSG_LEN]);
      tick;
      check("scroll_offset", offset, exp_off(c));
      check("scroll_wrap", wrap, exp_wrap(c));
      sb_check("scroll_code");
      prev = exp_off(c);
    end

    // Enable dropped on the very cycle of the step at offset 4
    enable = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    enable = 1'b1;
    for (int c = 0; c < 5 * STEP_DIV; c++) begin
      tick;
      check("pre_drop_offset", offset, c / STEP_DIV);
    end
    enable = 1'b0;
    tick;
    check("drop_offset", offset, 4);
    check("drop_wrap", wrap, 0);
    repeat (2) begin
      tick;
      check("idle_offset", offset, 4);
    end
    enable = 1'b1;
    tick;
    check("reen_offset0", offset, 4);
    for (int k = 1; k <= STEP_DIV; k++) begin
      tick;
      check("reen_offset", offset, (k < STEP_DIV) ? 4 : 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
